// File: rtl/ysyx_22050133_ifu_fetch_bridge_pkg.sv
// Shared types and constants for the instruction-fetch memory bridge.
// The reset PC is also consumed by the fetch stage.
package ysyx_22050133_ifu_fetch_bridge_pkg;

   localparam int unsigned XLEN   = 64;
   localparam int unsigned INST_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_AR   = 2'd1,
      ST_R    = 2'd2
   } fetch_state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [XLEN-1:0] RESET_PC = 64'h8000_0000;

   typedef struct packed {
      logic [XLEN-1:0] data;
      logic            err;
   } fetch_beat_t;

   // Odd-word PCs take the instruction from the upper half of the 8-byte beat.
   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] beat,
                                                  input logic            sel);
      return sel ? {INST_W'(0), beat[XLEN-1:INST_W]} : beat;
   endfunction

endpackage

// File: rtl/ysyx_22050133_fetch_outbuf.sv
// Single-entry output register towards decode: holds the fetched word until
// the consumer takes it, or until a redirect invalidates it.
module ysyx_22050133_fetch_outbuf
   import ysyx_22050133_ifu_fetch_bridge_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            i_load,
   input  fetch_beat_t     i_beat,
   input  logic            i_ready,
   input  logic            i_flush,
   output logic [XLEN-1:0] o_data,
   output logic            o_err,
   output logic            o_valid
);

   fetch_beat_t r_beat;
   logic        r_valid;

   // A load only happens with no flush and an empty (or draining) entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_beat  <= '0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_beat  <= i_beat;
         r_valid <= 1'b1;
      end else if (i_flush || i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_data  = r_beat.data;
   assign o_err   = r_beat.err;
   assign o_valid = r_valid;

endmodule

// File: rtl/ysyx_22050133_ifu_fetch_bridge.sv
// Fetch-side AXI4-Lite read bridge: one read per accepted PC, a single fetch
// in flight, and redirect-aware discard of stale responses.
module ysyx_22050133_ifu_fetch_bridge
   import ysyx_22050133_ifu_fetch_bridge_pkg::*;
#(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned RESET_PC_ALIGN = 3
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [XLEN-1:0]   pc_i,
   input  logic              pc_valid_i,
   output logic              pc_ready_o,
   input  logic              flush_i,
   output logic [ADDR_W-1:0] araddr_o,
   output logic              arvalid_o,
   input  logic              arready_i,
   input  logic [XLEN-1:0]   rdata_i,
   input  logic [1:0]        rresp_i,
   input  logic              rvalid_i,
   output logic              rready_o,
   output logic [XLEN-1:0]   inst64_o,
   output logic              inst_valid_o,
   input  logic              inst_ready_i,
   output logic              fetch_err_o
);

   fetch_state_e      r_state;
   fetch_state_e      w_state_nxt;
   logic [ADDR_W-1:0] r_araddr;
   logic              r_sel;
   logic              r_drop;

   logic              w_pc_ready;
   logic              w_accept;
   logic              w_deliver;
   logic              w_arvalid;
   logic              w_rready;
   logic              w_inst_valid;
   fetch_beat_t       w_beat;
   logic              w_unused_pc;

   assign w_unused_pc = ^{pc_i[XLEN-1:ADDR_W], pc_i[RESET_PC_ALIGN-2:0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept)  w_state_nxt = ST_AR;
         ST_AR:   if (arready_i) w_state_nxt = ST_R;
         ST_R:    if (rvalid_i)  w_state_nxt = ST_IDLE;
         default:                w_state_nxt = ST_IDLE;
      endcase
   end

   // Only one fetch in flight; a redirect cycle never accepts the stale PC.
   always_comb begin
      w_arvalid  = 1'b0;
      w_rready   = 1'b0;
      w_pc_ready = 1'b0;
      w_accept   = 1'b0;
      w_deliver  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_pc_ready = !flush_i && (!w_inst_valid || inst_ready_i);
            w_accept   = pc_valid_i && w_pc_ready;
         end
         ST_AR:   w_arvalid = 1'b1;
         ST_R: begin
            w_rready  = 1'b1;
            w_deliver = rvalid_i && !r_drop && !flush_i;
         end
         default: ;
      endcase
   end

   // Request address and beat-half select are captured at acceptance; a
   // redirect during AR/R marks the outstanding response for discard.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_araddr <= '0;
         r_sel    <= 1'b0;
         r_drop   <= 1'b0;
      end else if (w_accept) begin
         r_araddr <= {pc_i[ADDR_W-1:RESET_PC_ALIGN], {RESET_PC_ALIGN{1'b0}}};
         r_sel    <= pc_i[RESET_PC_ALIGN-1];
         r_drop   <= 1'b0;
      end else if (flush_i && (r_state != ST_IDLE)) begin
         r_drop   <= 1'b1;
      end
   end

   assign w_beat.data = align_word(rdata_i, r_sel);
   assign w_beat.err  = (rresp_i != RESP_OKAY);

   ysyx_22050133_fetch_outbuf u_outbuf (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_deliver),
      .i_beat  (w_beat),
      .i_ready (inst_ready_i),
      .i_flush (flush_i),
      .o_data  (inst64_o),
      .o_err   (fetch_err_o),
      .o_valid (w_inst_valid)
   );

   assign pc_ready_o   = w_pc_ready;
   assign araddr_o     = r_araddr;
   assign arvalid_o    = w_arvalid;
   assign rready_o     = w_rready;
   assign inst_valid_o = w_inst_valid;

endmodule

// File: tb/tb_ysyx_22050133_ifu_fetch_bridge.sv
// Scenario bench for the fetch bridge: expected words are queued at PC
// acceptance and checked when the bridge presents them to the consumer.
module tb_ysyx_22050133_ifu_fetch_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] pc_i;
   logic        pc_valid_i;
   logic        pc_ready_o;
   logic        flush_i;
   logic [31:0] araddr_o;
   logic        arvalid_o;
   logic        arready_i;
   logic [63:0] rdata_i;
   logic [1:0]  rresp_i;
   logic        rvalid_i;
   logic        rready_o;
   logic [63:0] inst64_o;
   logic        inst_valid_o;
   logic        inst_ready_i;
   logic        fetch_err_o;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [63:0] data;
      logic        err;
   } exp_t;
   exp_t sb[$];

   ysyx_22050133_ifu_fetch_bridge #(.ADDR_W(32), .RESET_PC_ALIGN(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .pc_i         (pc_i),
      .pc_valid_i   (pc_valid_i),
      .pc_ready_o   (pc_ready_o),
      .flush_i      (flush_i),
      .araddr_o     (araddr_o),
      .arvalid_o    (arvalid_o),
      .arready_i    (arready_i),
      .rdata_i      (rdata_i),
      .rresp_i      (rresp_i),
      .rvalid_i     (rvalid_i),
      .rready_o     (rready_o),
      .inst64_o     (inst64_o),
      .inst_valid_o (inst_valid_o),
      .inst_ready_i (inst_ready_i),
      .fetch_err_o  (fetch_err_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [63:0] d, input logic e);
      exp_t x;
      x.data = d;
      x.err  = e;
      sb.push_back(x);
   endtask

   task automatic issue(input logic [63:0] pc);
      pc_i       = pc;
      pc_valid_i = 1'b1;
      tick();
      pc_valid_i = 1'b0;
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (inst_valid_o) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic consume();
      inst_ready_i = 1'b1;
      tick();
      inst_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      tests++; if (arvalid_o !== 1'b0) begin fails++; $display("FAIL reset_arvalid: got %b expected 0", arvalid_o); end
      tests++; if (rready_o !== 1'b0) begin fails++; $display("FAIL reset_rready: got %b expected 0", rready_o); end
      tests++; if (inst_valid_o !== 1'b0) begin fails++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid_o); end
      tests++; if (fetch_err_o !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", fetch_err_o); end
      tests++; if (araddr_o !== 32'h0) begin fails++; $display("FAIL reset_araddr: got %h expected 0", araddr_o); end
      tests++; if (inst64_o !== 64'h0) begin fails++; $display("FAIL reset_inst64: got %h expected 0", inst64_o); end
   endtask

   task automatic test_basic();
      exp_t x;
      pc_i = 64'h8000_0000; pc_valid_i = 1'b1; arready_i = 1'b1;
      rvalid_i = 1'b1; rdata_i = 64'h00000013_00100093; rresp_i = 2'b00;
      #1;
      tests++; if (pc_ready_o !== 1'b1) begin fails++; $display("FAIL basic_pc_ready: got %b expected 1", pc_ready_o); end
      push_exp(64'h00000013_00100093, 1'b0);
      tick();
      pc_valid_i = 1'b0;
      tests++; if (arvalid_o !== 1'b1 || araddr_o !== 32'h8000_0000) begin fails++; $display("FAIL basic_ar: got arvalid=%b addr=%h expected 1/80000000", arvalid_o, araddr_o); end
      tick();
      tests++; if (rready_o !== 1'b1 || inst_valid_o !== 1'b0) begin fails++; $display("FAIL basic_r: got rready=%b valid=%b expected 1/0", rready_o, inst_valid_o); end
      tick();
      tests++; if (inst_valid_o !== 1'b1) begin fails++; $display("FAIL basic_latency: got valid=%b expected 1", inst_valid_o); end
      x = sb.pop_front();
      tests++; if (inst64_o[31:0] !== x.data[31:0] || inst64_o !== x.data) begin fails++; $display("FAIL basic_data: got %h expected %h", inst64_o, x.data); end
      tests++; if (fetch_err_o !== x.err) begin fails++; $display("FAIL basic_err: got %b expected %b", fetch_err_o, x.err); end
      consume();
      tests++; if (inst_valid_o !== 1'b0) begin fails++; $display("FAIL basic_clear: got %b expected 0", inst_valid_o); end
   endtask

   task automatic test_upper_half();
      exp_t x;
      bit   ok;
      issue(64'h8000_0004);
      push_exp(64'h0000_0000_0000_0013, 1'b0);
      tests++; if (araddr_o !== 32'h8000_0000) begin fails++; $display("FAIL upper_araddr: got %h expected 80000000", araddr_o); end
      wait_valid(10, ok);
      x = sb.pop_front();
      tests++; if (!ok || inst64_o !== x.data) begin fails++; $display("FAIL upper_data: got valid=%b %h expected %h", ok, inst64_o, x.data); end
      consume();
   endtask

   task automatic test_ar_stall();
      exp_t x;
      bit   ok;
      arready_i = 1'b0; rvalid_i = 1'b0;
      issue(64'h8000_0008);
      pc_i = 64'h8000_0040; pc_valid_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         tests++;
         if (arvalid_o !== 1'b1 || araddr_o !== 32'h8000_0008 || pc_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL stall_hold[%0d]: got arvalid=%b addr=%h pc_ready=%b expected 1/80000008/0", i, arvalid_o, araddr_o, pc_ready_o);
         end
         tick();
      end
      pc_valid_i = 1'b0; arready_i = 1'b1; rvalid_i = 1'b1;
      rdata_i = 64'h1122_3344_5566_7788;
      push_exp(64'h1122_3344_5566_7788, 1'b0);
      wait_valid(10, ok);
      x = sb.pop_front();
      tests++; if (!ok || inst64_o !== x.data) begin fails++; $display("FAIL stall_data: got valid=%b %h expected %h", ok, inst64_o, x.data); end
      consume();
   endtask

   task automatic test_flush_in_r();
      exp_t x;
      bit   ok;
      bit   leaked;
      arready_i = 1'b1; rvalid_i = 1'b0;
      issue(64'h8000_0010);
      tick();
      tests++; if (rready_o !== 1'b1) begin fails++; $display("FAIL flush_in_r_state: got rready=%b expected 1", rready_o); end
      flush_i = 1'b1;
      #1;
      tests++; if (pc_ready_o !== 1'b0) begin fails++; $display("FAIL flush_blocks_pc: got %b expected 0", pc_ready_o); end
      tick();
      flush_i = 1'b0;
      leaked = inst_valid_o;
      tick();
      leaked |= inst_valid_o;
      rvalid_i = 1'b1; rdata_i = 64'h0000_0000_0000_DEAD;
      tick();
      rvalid_i = 1'b0;
      leaked |= inst_valid_o;
      #1;
      tests++; if (pc_ready_o !== 1'b1 || rready_o !== 1'b0) begin fails++; $display("FAIL flush_return_idle: got pc_ready=%b rready=%b expected 1/0", pc_ready_o, rready_o); end
      tick();
      leaked |= inst_valid_o;
      tests++; if (leaked !== 1'b0) begin fails++; $display("FAIL flush_discard: got leaked=%b expected 0", leaked); end
      rvalid_i = 1'b1; rdata_i = 64'hCAFE_0000_0000_0517;
      issue(64'h8000_0100);
      push_exp(64'hCAFE_0000_0000_0517, 1'b0);
      tests++; if (araddr_o !== 32'h8000_0100) begin fails++; $display("FAIL flush_refetch_addr: got %h expected 80000100", araddr_o); end
      wait_valid(10, ok);
      x = sb.pop_front();
      tests++; if (!ok || inst64_o !== x.data) begin fails++; $display("FAIL flush_refetch_data: got valid=%b %h expected %h", ok, inst64_o, x.data); end
      consume();
   endtask

   task automatic test_flush_edges();
      bit ok;
      arready_i = 1'b1; rvalid_i = 1'b0;
      issue(64'h8000_0028);
      tick();
      rvalid_i = 1'b1; rdata_i = 64'h0000_0000_0000_BEEF; flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      tests++; if (inst_valid_o !== 1'b0 || rready_o !== 1'b0) begin fails++; $display("FAIL flush_with_rvalid: got valid=%b rready=%b expected 0/0", inst_valid_o, rready_o); end
      issue(64'h8000_0030);
      wait_valid(10, ok);
      tests++; if (!ok) begin fails++; $display("FAIL flush_idle_setup: got valid=%b expected 1", ok); end
      flush_i = 1'b1; inst_ready_i = 1'b1;
      tick();
      flush_i = 1'b0; inst_ready_i = 1'b0;
      tests++; if (inst_valid_o !== 1'b0) begin fails++; $display("FAIL flush_idle_clear: got %b expected 0", inst_valid_o); end
   endtask

   task automatic test_backpressure();
      exp_t x;
      bit   ok;
      arready_i = 1'b1; rvalid_i = 1'b1; rdata_i = 64'h0BAD_F00D_1234_5678;
      issue(64'h8000_0018);
      push_exp(64'h0BAD_F00D_1234_5678, 1'b0);
      wait_valid(10, ok);
      tests++; if (!ok) begin fails++; $display("FAIL bp_deliver: got valid=%b expected 1", ok); end
      pc_i = 64'h8000_0020; pc_valid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         tests++;
         if (inst_valid_o !== 1'b1 || inst64_o !== 64'h0BAD_F00D_1234_5678 || pc_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold[%0d]: got valid=%b data=%h pc_ready=%b expected 1/0badf00d12345678/0", i, inst_valid_o, inst64_o, pc_ready_o);
         end
         tick();
      end
      inst_ready_i = 1'b1;
      #1;
      tests++; if (pc_ready_o !== 1'b1) begin fails++; $display("FAIL bp_accept_ready: got %b expected 1", pc_ready_o); end
      x = sb.pop_front();
      tests++; if (inst64_o !== x.data || fetch_err_o !== x.err) begin fails++; $display("FAIL bp_data: got %h/%b expected %h/%b", inst64_o, fetch_err_o, x.data, x.err); end
      rdata_i = 64'h5555_AAAA_0000_0297;
      push_exp(64'h5555_AAAA_0000_0297, 1'b0);
      tick();
      pc_valid_i = 1'b0; inst_ready_i = 1'b0;
      tests++; if (inst_valid_o !== 1'b0 || arvalid_o !== 1'b1 || araddr_o !== 32'h8000_0020) begin fails++; $display("FAIL bp_accept_clear: got valid=%b arvalid=%b addr=%h expected 0/1/80000020", inst_valid_o, arvalid_o, araddr_o); end
      wait_valid(10, ok);
      x = sb.pop_front();
      tests++; if (!ok || inst64_o !== x.data) begin fails++; $display("FAIL bp_second: got valid=%b %h expected %h", ok, inst64_o, x.data); end
      consume();
   endtask

   task automatic test_error();
      exp_t x;
      bit   ok;
      arready_i = 1'b1; rvalid_i = 1'b1; rresp_i = 2'b10;
      rdata_i = 64'h0000_0000_0000_0073;
      issue(64'h8000_0038);
      push_exp(64'h0000_0000_0000_0073, 1'b1);
      wait_valid(10, ok);
      x = sb.pop_front();
      tests++; if (!ok || fetch_err_o !== x.err) begin fails++; $display("FAIL error_flag: got valid=%b err=%b expected 1/%b", ok, fetch_err_o, x.err); end
      tests++; if (inst64_o !== x.data) begin fails++; $display("FAIL error_data: got %h expected %h", inst64_o, x.data); end
      rresp_i = 2'b00;
      consume();
   endtask

   task automatic test_reset_mid();
      arready_i = 1'b0; rvalid_i = 1'b0;
      issue(64'h8000_0048);
      tests++; if (arvalid_o !== 1'b1) begin fails++; $display("FAIL rstmid_setup: got arvalid=%b expected 1", arvalid_o); end
      #1 rst = 1'b0;
      #1;
      tests++;
      if (arvalid_o !== 1'b0 || rready_o !== 1'b0 || inst_valid_o !== 1'b0 ||
          fetch_err_o !== 1'b0 || araddr_o !== 32'h0 || inst64_o !== 64'h0) begin
         fails++;
         $display("FAIL rstmid_async: got arvalid=%b rready=%b valid=%b err=%b addr=%h data=%h expected all 0",
                  arvalid_o, rready_o, inst_valid_o, fetch_err_o, araddr_o, inst64_o);
      end
      #1 rst = 1'b1;
      tick();
      tests++; if (arvalid_o !== 1'b0 || rready_o !== 1'b0) begin fails++; $display("FAIL rstmid_idle: got arvalid=%b rready=%b expected 0/0", arvalid_o, rready_o); end
      tests++; if (sb.size() != 0) begin fails++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size()); end
   endtask

   initial begin
      pc_i = '0; pc_valid_i = 1'b0; flush_i = 1'b0; arready_i = 1'b0;
      rdata_i = '0; rresp_i = 2'b00; rvalid_i = 1'b0; inst_ready_i = 1'b0;
      rst = 1'b1;
      #1 rst = 1'b0;
      #2;
      test_reset();
      #9 rst = 1'b1;
      tick();
      test_basic();
      test_upper_half();
      test_ar_stall();
      test_flush_in_r();
      test_flush_edges();
      test_backpressure();
      test_error();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ysyx_22050133_ifu_fetch_bridge.md
Name: ysyx_22050133_ifu_fetch_bridge

Overview:
- Instruction-side memory bridge directly downstream of the fetch (PC) stage.
- Consumes the fetch stage's PC valid/ready handshake and issues one AXI4-Lite read per PC.
- Returns the aligned 64-bit instruction word to the fetch stage, with its own valid/ready handshake.
- Discards in-flight fetches on a control-flow redirect (flush), so stale instructions never reach decode.

Parameters:
- ADDR_W, 32, width of the AXI read address; carries pc_i[ADDR_W-1:0] with bits [2:0] cleared.
- RESET_PC_ALIGN, 3, number of low address bits forced to zero (8-byte beats).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  reset, asynchronous assert, active-low.
- pc_i  in  64  fetch PC.
- pc_valid_i  in  1  pc_i valid.
- pc_ready_o  out  1  bridge accepts pc_i this cycle.
- flush_i  in  1  redirect; kill outstanding and buffered fetch.
- araddr_o  out  ADDR_W  AXI read address.
- arvalid_o  out  1  AXI AR valid.
- arready_i  in  1  AXI AR ready.
- rdata_i  in  64  AXI read data.
- rresp_i  in  2  AXI read response.
- rvalid_i  in  1  AXI R valid.
- rready_o  out  1  AXI R ready.
- inst64_o  out  64  fetched word, instruction in [31:0].
- inst_valid_o  out  1  inst64_o valid.
- inst_ready_i  in  1  consumer takes inst64_o.
- fetch_err_o  out  1  rresp_i != OKAY on the delivered word; qualified by inst_valid_o.

Behaviour:
- Reset (rst low, async):
  - state=IDLE, drop=0.
  - arvalid_o=0, rready_o=0, inst_valid_o=0, fetch_err_o=0.
  - araddr_o=0, inst64_o=0.
- States:
  - IDLE: no transaction outstanding.
  - AR: arvalid_o=1.
  - R: rready_o=1.
- pc_ready_o = (state==IDLE) && !flush_i && (!inst_valid_o || inst_ready_i). This is combinational and holds only one fetch in flight.
- IDLE -> AR on pc_valid_i && pc_ready_o:
  - latch araddr_o = {pc_i[ADDR_W-1:3],3'b000}.
  - latch pc_i[2] into sel.
  - drop=0.
  - If inst_ready_i && inst_valid_o in the same cycle, clear inst_valid_o.
- AR:
  - arvalid_o and araddr_o stay stable until arready_i (AXI rule: never retract).
  - On arready_i -> R on the next cycle. arvalid_o falls the same edge.
- R -> IDLE on rvalid_i (rready_o=1 throughout R):
  - if drop==0 and flush_i==0: inst64_o = sel ? {32'h0, rdata_i[63:32]} : rdata_i; fetch_err_o = (rresp_i!=2'b00); inst_valid_o=1.
  - otherwise: response is discarded and inst_valid_o stays 0.
- Latency: with arready_i and rvalid_i asserted at first opportunity, inst_valid_o rises 3 cycles after PC acceptance.
  - Cycle 0: accept.
  - Cycle 1: AR.
  - Cycle 2: R.
  - Cycle 3: valid.
- Output hold: inst64_o, fetch_err_o and inst_valid_o stay stable while inst_valid_o && !inst_ready_i. inst_valid_o clears on inst_ready_i.
- Flush:
  - In IDLE: clears inst_valid_o next edge.
  - In AR or R: sets drop=1. The transaction completes on the bus and its data is discarded.
  - flush_i blocks pc_ready_o in its own cycle. The redirected PC is accepted from the following cycle, once state==IDLE.
- Simultaneous events:
  - flush_i with rvalid_i in R: data discarded.
  - flush_i with inst_ready_i in IDLE: inst_valid_o cleared (same result).
- Error responses: no retry. Data is still forwarded with fetch_err_o=1; the exception decision belongs downstream.
- Reset mid-transaction: state returns to IDLE immediately, with no bus cleanup. The interconnect is reset by the same rst.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'd0, AR=2'd1, R=2'd2);
  - AXI response constants (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11);
  - the reset PC constant 64'h8000_0000, shared with the fetch stage.
- One natural sub-module: ysyx_22050133_fetch_outbuf, the single-entry output register (inst64/err/valid with ready-clear and flush-clear). The FSM stays in the top module.

Test Plan:
- Reset release, pc_i=64'h8000_0000 valid, arready_i=1, rvalid_i=1 next, rdata_i=64'h00000013_00100093 -> araddr_o=32'h8000_0000; inst64_o[31:0]=32'h00100093 three cycles after accept; fetch_err_o=0.
- pc_i=64'h8000_0004, same rdata_i -> araddr_o=32'h8000_0000; inst64_o=64'h0000_0000_0000_0013.
- arready_i held low 4 cycles -> arvalid_o stays 1 and araddr_o stable for 4 cycles; pc_ready_o=0 throughout.
- flush_i pulsed while in R, rvalid_i arriving 2 cycles later with 64'hDEAD -> inst_valid_o never rises; pc_ready_o=1 the cycle after return to IDLE; new pc 64'h8000_0100 fetched normally.
- inst_ready_i held 0 after delivery -> inst64_o stable and pc_ready_o=0; inst_ready_i=1 with pc_valid_i=1 -> accept and clear in the same cycle.
- rresp_i=2'b10 -> inst_valid_o=1 with fetch_err_o=1. Async rst low mid-AR -> all outputs 0 without a clock edge.
